// File: rtl/cuckoo_bucket_probe_if.sv
// Request/response bundle between the cuckoo bucket probe and its client.
interface cuckoo_bucket_probe_if #(
    parameter int unsigned NUM_HASH_FUNC  = 2,
    parameter int unsigned LG_NUM_BUCKETS = 10,
    parameter int unsigned SLOTS          = 4,
    parameter int unsigned TAG_WIDTH      = 11
);
    localparam int unsigned FUNC_W = (NUM_HASH_FUNC > 1) ? $clog2(NUM_HASH_FUNC) : 1;
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned IDX_W  = NUM_HASH_FUNC * LG_NUM_BUCKETS;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_op;
    logic [TAG_WIDTH-1:0] req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_hit;
    logic [FUNC_W-1:0]    resp_func;
    logic [SLOT_W-1:0]    resp_slot;
    logic                 resp_full;

    modport master (
        output req_valid, req_op, req_tag, req_idx, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_func, resp_slot, resp_full
    );

    modport slave (
        input  req_valid, req_op, req_tag, req_idx, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_func, resp_slot, resp_full
    );
endinterface

// File: rtl/cuckoo_bucket_probe.sv
// Cuckoo address-map storage stage: probes one candidate bucket per cycle,
// reports the hit location, or places a new tag in the first free slot seen.
module cuckoo_bucket_probe #(
    parameter int unsigned NUM_HASH_FUNC  = 2,
    parameter int unsigned LG_NUM_BUCKETS = 10,
    parameter int unsigned SLOTS          = 4,
    parameter int unsigned TAG_WIDTH      = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cuckoo_bucket_probe_if.slave  bus
);
    localparam int unsigned NUM_BUCKETS = 1 << LG_NUM_BUCKETS;
    localparam int unsigned FUNC_W      = (NUM_HASH_FUNC > 1) ? $clog2(NUM_HASH_FUNC) : 1;
    localparam int unsigned SLOT_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned IDX_W       = NUM_HASH_FUNC * LG_NUM_BUCKETS;
    localparam int unsigned ENTRY_W     = TAG_WIDTH + 1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_PROBE, S_RESP} state_t;

    state_t                    state_q, state_d;
    logic [LG_NUM_BUCKETS-1:0] cnt_q, cnt_d;
    logic                      op_q, op_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [FUNC_W-1:0]         h_q, h_d;
    logic                      cand_q, cand_d;
    logic [FUNC_W-1:0]         cfunc_q, cfunc_d;
    logic [SLOT_W-1:0]         cslot_q, cslot_d;
    logic                      req_ready_q, resp_valid_q;
    logic                      hit_q, hit_d, full_q, full_d;
    logic [FUNC_W-1:0]         func_q, func_d;
    logic [SLOT_W-1:0]         slot_q, slot_d;

    logic                      clr_en_c, wr_en_c;
    logic [LG_NUM_BUCKETS-1:0] probe_bkt_c, wr_bkt_c;
    logic                      match_c, free_c;
    logic [SLOT_W-1:0]         match_slot_c, free_slot_c;

    // Entry layout: {valid, tag}
    logic [ENTRY_W-1:0] mem [NUM_BUCKETS][SLOTS];

    assign probe_bkt_c = idx_q[32'(h_q) * LG_NUM_BUCKETS +: LG_NUM_BUCKETS];
    assign wr_bkt_c    = idx_q[32'(cfunc_d) * LG_NUM_BUCKETS +: LG_NUM_BUCKETS];

    // Lowest matching slot and lowest free slot of the bucket under probe
    always_comb begin
        match_c      = 1'b0;
        match_slot_c = '0;
        free_c       = 1'b0;
        free_slot_c  = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (mem[probe_bkt_c][s][TAG_WIDTH] && (mem[probe_bkt_c][s][TAG_WIDTH-1:0] == tag_q)) begin
                match_c      = 1'b1;
                match_slot_c = SLOT_W'(s);
            end
            if (!mem[probe_bkt_c][s][TAG_WIDTH]) begin
                free_c      = 1'b1;
                free_slot_c = SLOT_W'(s);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        tag_d    = tag_q;
        idx_d    = idx_q;
        h_d      = h_q;
        cand_d   = cand_q;
        cfunc_d  = cfunc_q;
        cslot_d  = cslot_q;
        hit_d    = hit_q;
        full_d   = full_q;
        func_d   = func_q;
        slot_d   = slot_q;
        clr_en_c = 1'b0;
        wr_en_c  = 1'b0;
        case (state_q)
            S_INIT: begin
                clr_en_c = 1'b1;
                cnt_d    = cnt_q + LG_NUM_BUCKETS'(1);
                if (cnt_q == LG_NUM_BUCKETS'(NUM_BUCKETS - 1)) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    op_d    = bus.req_op;
                    tag_d   = bus.req_tag;
                    idx_d   = bus.req_idx;
                    h_d     = '0;
                    cand_d  = 1'b0;
                    cfunc_d = '0;
                    cslot_d = '0;
                    state_d = S_PROBE;
                end
            end
            S_PROBE: begin
                if (match_c) begin
                    hit_d   = 1'b1;
                    full_d  = 1'b0;
                    func_d  = h_q;
                    slot_d  = match_slot_c;
                    state_d = S_RESP;
                end else begin
                    if (!cand_q && free_c) begin
                        cand_d  = 1'b1;
                        cfunc_d = h_q;
                        cslot_d = free_slot_c;
                    end
                    if (h_q != FUNC_W'(NUM_HASH_FUNC - 1)) begin
                        h_d = h_q + FUNC_W'(1);
                    end else begin
                        hit_d   = 1'b0;
                        full_d  = 1'b0;
                        func_d  = '0;
                        slot_d  = '0;
                        state_d = S_RESP;
                        if (op_q) begin
                            if (cand_d) begin
                                wr_en_c = 1'b1;
                                func_d  = cfunc_d;
                                slot_d  = cslot_d;
                            end else begin
                                full_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            cnt_q        <= '0;
            op_q         <= 1'b0;
            tag_q        <= '0;
            idx_q        <= '0;
            h_q          <= '0;
            cand_q       <= 1'b0;
            cfunc_q      <= '0;
            cslot_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            full_q       <= 1'b0;
            func_q       <= '0;
            slot_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            h_q          <= h_d;
            cand_q       <= cand_d;
            cfunc_q      <= cfunc_d;
            cslot_q      <= cslot_d;
            req_ready_q  <= (state_d == S_IDLE);
            resp_valid_q <= (state_d == S_RESP);
            hit_q        <= hit_d;
            full_q       <= full_d;
            func_q       <= func_d;
            slot_q       <= slot_d;
        end
    end

    // Table storage: whole-bucket clear during INIT, single-entry insert write
    always_ff @(posedge clk) begin
        if (rst_n && clr_en_c) begin
            for (int s = 0; s < SLOTS; s++) mem[cnt_q][s] <= '0;
        end else if (rst_n && wr_en_c) begin
            mem[wr_bkt_c][cslot_d] <= {1'b1, tag_q};
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit   = hit_q;
    assign bus.resp_full  = full_q;
    assign bus.resp_func  = func_q;
    assign bus.resp_slot  = slot_q;
endmodule

// File: tb/tb_cuckoo_bucket_probe.sv
// Bench for cuckoo_bucket_probe: directed scenarios plus random traffic
// checked against a flat-array model of the bucket table.
module tb_cuckoo_bucket_probe;
    localparam int unsigned NH = 2;
    localparam int unsigned LG = 10;
    localparam int unsigned SL = 4;
    localparam int unsigned TW = 11;
    localparam int unsigned NB = 1 << LG;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cuckoo_bucket_probe_if #(.NUM_HASH_FUNC(NH), .LG_NUM_BUCKETS(LG), .SLOTS(SL), .TAG_WIDTH(TW)) bus ();

    cuckoo_bucket_probe #(.NUM_HASH_FUNC(NH), .LG_NUM_BUCKETS(LG), .SLOTS(SL), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int fails  = 0;

    bit            mv [NB][SL];
    logic [TW-1:0] mt [NB][SL];

    // Observed fields of the most recent transaction
    logic r_hit, r_full;
    int   r_func, r_slot, r_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < NB; b++)
            for (int s = 0; s < SL; s++) mv[b][s] = 1'b0;
    endtask

    // Search candidate buckets in function order; first match wins,
    // otherwise an insert takes the first free (func, slot) in that order.
    task automatic model_probe(input bit op, input logic [TW-1:0] tag, input int i0, input int i1,
                               output bit hit, output bit full, output int func, output int slot,
                               output int lat);
        int ix [2];
        int cf, cs;
        ix[0] = i0; ix[1] = i1;
        hit = 1'b0; full = 1'b0; func = 0; slot = 0; lat = NH;
        cf = -1; cs = -1;
        for (int h = 0; h < NH; h++) begin
            for (int s = 0; s < SL; s++) begin
                if (!hit && mv[ix[h]][s] && mt[ix[h]][s] == tag) begin
                    hit = 1'b1; func = h; slot = s; lat = h + 1;
                end
                if (cf < 0 && !mv[ix[h]][s]) begin
                    cf = h; cs = s;
                end
            end
        end
        if (!hit && op) begin
            if (cf >= 0) begin
                func = cf; slot = cs;
                mv[ix[cf]][cs] = 1'b1;
                mt[ix[cf]][cs] = tag;
            end else begin
                full = 1'b1;
            end
        end
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.req_ready && n < 3000);
        chk("init_cycles", 32'(n), 32'd1024);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_hit", 32'(bus.resp_hit), 0);
        chk("rst_resp_full", 32'(bus.resp_full), 0);
        chk("rst_resp_func", 32'(bus.resp_func), 0);
        chk("rst_resp_slot", 32'(bus.resp_slot), 0);
        rst_n = 1'b1;
        model_clear();
        wait_init();
    endtask

    task automatic drive_req(input bit op, input logic [TW-1:0] tag, input int i0, input int i1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_tag   = tag;
        bus.req_idx   = {LG'(i1), LG'(i0)};
    endtask

    // One full transaction; must be called #1 after a rising edge
    task automatic txn(input bit op, input logic [TW-1:0] tag, input int i0, input int i1, input int hold);
        bit e_hit, e_full;
        int e_func, e_slot, e_lat, n;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_idle", 32'(bus.req_ready), 1);
        model_probe(op, tag, i0, i1, e_hit, e_full, e_func, e_slot, e_lat);
        drive_req(op, tag, i0, i1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("req_ready_busy", 32'(bus.req_ready), 0);
        r_lat = 0;
        while (!bus.resp_valid && r_lat < 20) begin
            @(posedge clk); #1;
            r_lat++;
        end
        r_hit = bus.resp_hit; r_full = bus.resp_full;
        r_func = int'(bus.resp_func); r_slot = int'(bus.resp_slot);
        chk("resp_latency", 32'(r_lat), 32'(e_lat));
        chk("resp_hit", 32'(bus.resp_hit), 32'(e_hit));
        chk("resp_full", 32'(bus.resp_full), 32'(e_full));
        chk("resp_func", 32'(bus.resp_func), 32'(e_func));
        chk("resp_slot", 32'(bus.resp_slot), 32'(e_slot));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.resp_valid), 1);
            chk("hold_ready", 32'(bus.req_ready), 0);
            chk("hold_fields", {bus.resp_hit, bus.resp_full, 30'(bus.resp_func), 30'(bus.resp_slot)} == 32'b0 ? 32'd0 :
                32'({bus.resp_hit, bus.resp_full, 4'(bus.resp_func), 4'(bus.resp_slot)}),
                32'({e_hit, e_full, 4'(e_func), 4'(e_slot)}));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("post_hs_valid", 32'(bus.resp_valid), 0);
        chk("post_hs_ready", 32'(bus.req_ready), 1);
    endtask

    initial begin
        logic [TW-1:0] t;
        int exp_slot [8];
        int exp_func [8];
        bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_tag = '0; bus.req_idx = '0;
        bus.resp_ready = 1'b0;

        do_reset();

        // Empty-table lookup and first insert / lookup
        txn(1'b0, 11'h155, 5, 9, 0);
        chk("dir_empty_hit", 32'(r_hit), 0);
        chk("dir_empty_lat", 32'(r_lat), 2);
        txn(1'b1, 11'h2AA, 3, 7, 0);
        chk("dir_ins_slot", 32'({r_hit, 4'(r_func), 4'(r_slot)}), 32'h000);
        chk("dir_ins_lat", 32'(r_lat), 2);
        txn(1'b0, 11'h2AA, 3, 7, 0);
        chk("dir_lkp_hit", 32'({r_hit, 4'(r_func), 4'(r_slot)}), 32'h100);
        chk("dir_lkp_lat", 32'(r_lat), 1);

        // Duplicate insert must not consume a slot
        txn(1'b1, 11'h2AA, 3, 7, 0);
        chk("dir_dup_hit", 32'({r_hit, 4'(r_func), 4'(r_slot)}), 32'h100);

        // Fill func 0 then func 1, then overflow
        exp_func = '{0, 0, 0, 1, 1, 1, 1, 0};
        exp_slot = '{1, 2, 3, 0, 1, 2, 3, 0};
        for (int k = 0; k < 7; k++) begin
            t = 11'h300 + TW'(k);
            txn(1'b1, t, 3, 7, 0);
            chk("dir_fill_func", 32'(r_func), 32'(exp_func[k]));
            chk("dir_fill_slot", 32'(r_slot), 32'(exp_slot[k]));
        end
        txn(1'b1, 11'h307, 3, 7, 0);
        chk("dir_full", 32'({r_full, r_hit}), 32'b10);
        txn(1'b0, 11'h307, 3, 7, 0);
        chk("dir_full_lookup", 32'(r_hit), 0);
        txn(1'b0, 11'h306, 3, 7, 0);
        chk("dir_h1_hit", 32'({r_hit, 4'(r_func), 4'(r_slot)}), 32'h113);
        chk("dir_h1_lat", 32'(r_lat), 2);

        // Backpressure, and identical indices for both functions
        txn(1'b0, 11'h2AA, 3, 7, 5);
        txn(1'b1, 11'h010, 20, 20, 0);
        chk("dir_same_idx_ins", 32'({4'(r_func), 4'(r_slot)}), 32'h00);
        txn(1'b0, 11'h010, 20, 20, 0);
        chk("dir_same_idx_lkp", 32'({r_hit, 4'(r_func)}), 32'h10);

        // Random traffic over a small tag/index space to force collisions
        for (int k = 0; k < 300; k++)
            txn(1'($urandom_range(0, 1)), TW'($urandom_range(0, 40)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));

        // Reset while probing
        drive_req(1'b1, 11'h3F0, 40, 41);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_probe_valid", 32'(bus.resp_valid), 0);
        chk("rst_probe_ready", 32'(bus.req_ready), 0);
        rst_n = 1'b1;
        model_clear();
        wait_init();
        txn(1'b0, 11'h2AA, 3, 7, 0);
        chk("after_rst_lookup", 32'(r_hit), 0);

        // Reset while the response is pending
        txn(1'b1, 11'h123, 50, 51, 0);
        drive_req(1'b0, 11'h123, 50, 51);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_resp_valid", 32'(bus.resp_valid), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_resp_edge_valid", 32'(bus.resp_valid), 0);
        rst_n = 1'b1;
        model_clear();
        wait_init();
        txn(1'b0, 11'h123, 50, 51, 0);
        chk("after_rst2_lookup", 32'(r_hit), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/cuckoo_bucket_probe.md
# cuckoo_bucket_probe

Downstream consumer of the address-mapping hash stage. Takes one tag plus the `NUM_HASH_FUNC` bucket indices produced for it, probes an internal bucket table one hash function per cycle, and returns a hit location. For inserts it either places the tag in the first free slot found or reports the table full. It is the storage and lookup stage of the cuckoo-style address map.

## Interface
- `NUM_HASH_FUNC`, default 2: number of candidate buckets per tag (≥1).
- `LG_NUM_BUCKETS`, default 10: log2 of the bucket count; must match the hash stage's `lg_num_buckets`.
- `SLOTS`, default 4: slots per bucket (power of two).
- `TAG_WIDTH`, default 11: stored tag width.

- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_op` input 1: 0 = lookup, 1 = insert.
- `req_tag` input `TAG_WIDTH`: tag to find or insert.
- `req_idx` input `NUM_HASH_FUNC*LG_NUM_BUCKETS`: bucket index for function h in bits `[h*LG_NUM_BUCKETS +: LG_NUM_BUCKETS]`.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer accepts the response.
- `resp_hit` output 1: tag already present in the table.
- `resp_func` output `$clog2(NUM_HASH_FUNC)` (min 1): hash function of the hit or insert location.
- `resp_slot` output `$clog2(SLOTS)` (min 1): slot of the hit or insert location.
- `resp_full` output 1: insert failed because no free slot was found.

## Operation
- Table: `2^LG_NUM_BUCKETS` buckets × `SLOTS` entries, each entry holding {valid, tag}. One bucket is read and at most one bucket is written per cycle.
- States: INIT, IDLE, PROBE, RESP.
- **INIT** (entered on reset):
  - A bucket counter sweeps 0 to 2^LG−1, clearing every valid bit of one bucket per cycle.
  - Exits to IDLE after the last bucket is cleared.
  - `req_ready`=0 throughout.
- **IDLE**:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch op, tag and indices, set h=0, clear the free-slot candidate, and go to PROBE.
- **PROBE** (one cycle per h): read bucket `idx[h]`.
  - Match (valid && tag equal): lowest matching slot wins. Set hit=1, func=h, slot=that slot, and go to RESP.
  - No match, candidate not yet set: record the lowest invalid slot of this bucket, if any, as the candidate (h, slot).
  - No match, h < `NUM_HASH_FUNC`−1: increment h.
  - No match, h = last, op = lookup: hit=0, full=0, func=0, slot=0; go to RESP.
  - No match, h = last, op = insert, candidate exists: write {1, tag} into the candidate entry on this edge. Respond hit=0, full=0, func/slot = candidate; go to RESP.
  - No match, h = last, op = insert, no candidate: no write. Respond hit=0, full=1, func=0, slot=0; go to RESP.
  - Duplicate insert (hit found) never writes.
- **RESP**:
  - `resp_valid`=1 with all response fields held stable until `resp_ready`.
  - On handshake, go to IDLE.
- Identical indices across functions are legal. The match is reported at the lowest h, and the candidate is taken from the lowest h.
- Reset in any state (including PROBE/RESP mid-transaction):
  - The pending transaction is dropped and `resp_valid` falls on that edge.
  - INIT re-runs, so all previous entries are lost.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_hit`=0, `resp_func`=0, `resp_slot`=0, `resp_full`=0.
- INIT lasts exactly 2^LG_NUM_BUCKETS cycles after the first cycle with `rst_n`=1; `req_ready` rises on the following edge.
- Request accepted at edge T:
  - Hit at function h: `resp_valid` high from edge T+1+h.
  - Miss, insert or full: `resp_valid` high from edge T+`NUM_HASH_FUNC`.
- The insert write commits at edge T+`NUM_HASH_FUNC`; the next request observes it.
- Throughput: one transaction in flight. `req_ready`=0 from acceptance until the cycle after the response handshake, so a new request is accepted no earlier than one edge after the response handshake.
- No combinational path from `req_valid` to `req_ready` or from `resp_ready` to `resp_valid`.

## Test plan
- **Reset/INIT** (LG=10): release `rst_n` → `req_ready`=0 for exactly 1024 cycles, then 1. Lookup tag 0x155, idx {5,9} → hit=0, full=0, response at T+2.
- **Insert then lookup**: insert tag 0x2AA, idx {3,7} → hit=0, func=0, slot=0 at T+2. Lookup 0x2AA, idx {3,7} → hit=1, func=0, slot=0 at T+1.
- **Overflow to second function and full**:
  - Insert 4 distinct tags at idx {3,7} → slots 0..3 of func 0.
  - 5th insert → func=1, slot=0.
  - After 4 more inserts at idx {3,7}, the next insert → full=1.
  - A lookup of that tag → hit=0.
- **Duplicate insert**: re-insert 0x2AA → hit=1, func=0, slot=0, no write. The next new tag at idx {3,7} takes slot 1.
- **Backpressure**: hold `resp_ready`=0 for 5 cycles → `resp_valid` and all fields stable, `req_ready`=0. Raise `resp_ready` → handshake, then IDLE.
- **Reset mid-transaction**: assert `rst_n`=0 during PROBE and separately during RESP → `resp_valid`=0 on that edge. After INIT, lookup of a previously inserted tag → hit=0.
